// File: rtl/memory_arbiter.sv
// N-way arbiter multiplexing upstream load/store requests onto one downstream memory port.
// Each transaction runs IDLE -> ISSUE -> RESPOND; every output is registered.
module memory_arbiter #(
    parameter int WAYS          = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ROUND_ROBIN   = 1,
    parameter int TIMEOUT       = 0
) (
    input  logic                                   clockIn,
    input  logic                                   resetIn,
    output logic [ADDRESS_WIDTH-1:0]               addressOut,
    output logic [DATA_WIDTH-1:0]                  valueOut,
    output logic                                   loadOut,
    output logic                                   storeOut,
    input  logic [DATA_WIDTH-1:0]                  valueIn,
    input  logic                                   readyIn,
    input  logic [WAYS-1:0][ADDRESS_WIDTH-1:0]     addressesIn,
    input  logic [WAYS-1:0][DATA_WIDTH-1:0]        valuesOutIn,
    input  logic [WAYS-1:0]                        loadBitsIn,
    input  logic [WAYS-1:0]                        storeBitsIn,
    output logic [WAYS-1:0][DATA_WIDTH-1:0]        valuesInOut,
    output logic [WAYS-1:0]                        readyBitsOut,
    output logic [WAYS-1:0]                        faultBitsOut,
    output logic                                   busyOut
);
    localparam int GW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic [CW-1:0]   count;
    logic [WAYS-1:0] req;
    logic            any_req;
    logic            found;
    int              idx;

    // Round-robin searches cyclically starting just after the previous winner.
    always_comb begin
        req     = loadBitsIn | storeBitsIn;
        any_req = |req;
        pick    = '0;
        cand    = '0;
        found   = 1'b0;
        idx     = 0;
        if (ROUND_ROBIN != 0) begin
            for (int off = 1; off <= WAYS; off++) begin
                idx = int'(last_grant) + off;
                if (idx >= WAYS) idx = idx - WAYS;
                cand = GW'(idx);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
        end else begin
            for (int i = WAYS - 1; i >= 0; i--) begin
                cand = GW'(i);
                if (req[cand]) pick = cand;
            end
        end
    end

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            state        <= IDLE;
            last_grant   <= GW'(WAYS - 1);
            grant        <= '0;
            count        <= '0;
            addressOut   <= '0;
            valueOut     <= '0;
            loadOut      <= 1'b0;
            storeOut     <= 1'b0;
            valuesInOut  <= '0;
            readyBitsOut <= '0;
            faultBitsOut <= '0;
            busyOut      <= 1'b0;
        end else begin
            readyBitsOut <= '0;
            faultBitsOut <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        addressOut <= addressesIn[pick];
                        // Store wins when a way raises both strobes.
                        storeOut   <= storeBitsIn[pick];
                        loadOut    <= loadBitsIn[pick] & ~storeBitsIn[pick];
                        valueOut   <= storeBitsIn[pick] ? valuesOutIn[pick] : '0;
                        count      <= '0;
                        busyOut    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (readyIn) begin
                        if (loadOut) valuesInOut[grant] <= valueIn;
                        readyBitsOut[grant] <= 1'b1;
                        addressOut <= '0;
                        valueOut   <= '0;
                        loadOut    <= 1'b0;
                        storeOut   <= 1'b0;
                        state      <= RESPOND;
                    end else if (TIMEOUT > 0 && count == CW'(TIMEOUT - 1)) begin
                        readyBitsOut[grant] <= 1'b1;
                        faultBitsOut[grant] <= 1'b1;
                        addressOut <= '0;
                        valueOut   <= '0;
                        loadOut    <= 1'b0;
                        storeOut   <= 1'b0;
                        state      <= RESPOND;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESPOND: begin
                    busyOut <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a round-robin/timeout instance (a) and a fixed-priority instance (b),
// with directed stimulus and a pulse-driven scoreboard.
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]      a_addr_out, a_val_out, a_rdata;
    logic             a_load_out, a_store_out, a_ready, a_busy;
    logic [3:0][31:0] a_addrs, a_wdata, a_values;
    logic [3:0]       a_load_bits, a_store_bits, a_ready_bits, a_fault_bits;

    logic [31:0]      b_addr_out, b_val_out, b_rdata;
    logic             b_load_out, b_store_out, b_ready, b_busy;
    logic [3:0][31:0] b_addrs, b_wdata, b_values;
    logic [3:0]       b_load_bits, b_store_bits, b_ready_bits, b_fault_bits;

    memory_arbiter #(.WAYS(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT(4)) dut_a (
        .clockIn(clk), .resetIn(rst),
        .addressOut(a_addr_out), .valueOut(a_val_out), .loadOut(a_load_out), .storeOut(a_store_out),
        .valueIn(a_rdata), .readyIn(a_ready),
        .addressesIn(a_addrs), .valuesOutIn(a_wdata), .loadBitsIn(a_load_bits), .storeBitsIn(a_store_bits),
        .valuesInOut(a_values), .readyBitsOut(a_ready_bits), .faultBitsOut(a_fault_bits), .busyOut(a_busy)
    );

    memory_arbiter #(.WAYS(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT(0)) dut_b (
        .clockIn(clk), .resetIn(rst),
        .addressOut(b_addr_out), .valueOut(b_val_out), .loadOut(b_load_out), .storeOut(b_store_out),
        .valueIn(b_rdata), .readyIn(b_ready),
        .addressesIn(b_addrs), .valuesOutIn(b_wdata), .loadBitsIn(b_load_bits), .storeBitsIn(b_store_bits),
        .valuesInOut(b_values), .readyBitsOut(b_ready_bits), .faultBitsOut(b_fault_bits), .busyOut(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Entry: {dut[35], way[34:33], fault[32], expected held value of that way[31:0]}
    logic [35:0] exp_q[$];
    logic [31:0] mon_vals[2][4];
    logic [35:0] m_e;
    logic        m_dut;
    logic [3:0]  m_rdy, m_flt;
    logic [3:0][31:0] m_vals;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit dut, input int way, input bit fault, input logic [31:0] val);
        exp_q.push_back({dut, 2'(way), fault, val});
    endtask

    // Scoreboard monitor: every ready/fault pulse pops one expected response.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int w = 0; w < 4; w++) mon_vals[d][w] = '0;
        end else if ((a_ready_bits | a_fault_bits | b_ready_bits | b_fault_bits) != 4'b0) begin
            m_dut  = ((b_ready_bits | b_fault_bits) != 4'b0);
            m_rdy  = m_dut ? b_ready_bits : a_ready_bits;
            m_flt  = m_dut ? b_fault_bits : a_fault_bits;
            m_vals = m_dut ? b_values : a_values;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {m_dut, m_rdy, m_flt}, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("pulse_dut", 64'(m_dut), 64'(m_e[35]));
                check("ready_bits", 64'(m_rdy), 64'(4'b0001 << m_e[34:33]));
                check("fault_bits", 64'(m_flt), m_e[32] ? 64'(4'b0001 << m_e[34:33]) : 64'd0);
                mon_vals[m_e[35]][m_e[34:33]] = m_e[31:0];
                for (int w = 0; w < 4; w++) check("held_value", 64'(m_vals[w]), 64'(mon_vals[m_e[35]][w]));
            end
        end
    end

    // Wait for dut_a's strobe, check the issued operation, then answer readyIn after `delay` ISSUE cycles.
    task automatic serve_a(input int delay, input bit give_ready, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_val,
                           input bit exp_store, output int hi);
        int waited = 0;
        hi = 0;
        @(negedge clk);
        while (!(a_load_out | a_store_out) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("strobe_rise", 64'(waited < 20), 64'd1);
        check("issue_addr", 64'(a_addr_out), 64'(exp_addr));
        check("issue_value", 64'(a_val_out), 64'(exp_val));
        check("issue_store", 64'(a_store_out), 64'(exp_store));
        check("issue_load", 64'(a_load_out), 64'(!exp_store));
        check("issue_busy", 64'(a_busy), 64'd1);
        for (int c = 0; c < 40; c++) begin
            if (!(a_load_out | a_store_out)) break;
            hi++;
            if (give_ready && c == delay) begin
                a_ready = 1'b1;
                a_rdata = rdata;
            end else begin
                a_ready = 1'b0;
            end
            @(negedge clk);
        end
        a_ready = 1'b0;
    endtask

    int hi;

    initial begin
        rst = 1'b1;
        a_addrs = '0; a_wdata = '0; a_load_bits = '0; a_store_bits = '0; a_ready = 1'b0; a_rdata = '0;
        b_addrs = '0; b_wdata = '0; b_load_bits = '0; b_store_bits = '0; b_ready = 1'b0; b_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_addr", 64'(a_addr_out), 64'd0);
        check("rst_value", 64'(a_val_out), 64'd0);
        check("rst_load", 64'(a_load_out), 64'd0);
        check("rst_store", 64'(a_store_out), 64'd0);
        check("rst_values", 64'(|a_values), 64'd0);
        check("rst_ready", 64'(a_ready_bits), 64'd0);
        check("rst_fault", 64'(a_fault_bits), 64'd0);
        check("rst_busy", 64'(a_busy | b_busy), 64'd0);
        #2 rst = 1'b0;

        // Single load on way 1, readyIn on the fourth ISSUE cycle.
        @(negedge clk);
        a_addrs[1] = 32'h100; a_wdata[1] = 32'h55; a_load_bits = 4'b0010;
        push(0, 1, 0, 32'hDEADBEEF);
        serve_a(3, 1, 32'hDEADBEEF, 32'h100, 32'h0, 0, hi);
        check("load_strobe_cycles", 64'(hi), 64'd4);
        a_load_bits = '0;

        // Load and store together on way 0: store wins, held value untouched.
        @(negedge clk);
        a_addrs[0] = 32'h200; a_wdata[0] = 32'h12345678; a_load_bits = 4'b0001; a_store_bits = 4'b0001;
        push(0, 0, 0, 32'h0);
        serve_a(0, 1, 32'hFFFFFFFF, 32'h200, 32'h12345678, 1, hi);
        check("store_strobe_cycles", 64'(hi), 64'd1);
        a_load_bits = '0; a_store_bits = '0;

        // Timeout: no readyIn, strobe for exactly 4 cycles, then fault pulse.
        @(negedge clk);
        a_addrs[2] = 32'h180; a_load_bits = 4'b0100;
        push(0, 2, 1, 32'h0);
        serve_a(0, 0, 32'h0, 32'h180, 32'h0, 0, hi);
        check("timeout_strobe_cycles", 64'(hi), 64'd4);
        a_load_bits = '0;

        // readyIn in the last allowed cycle completes without fault.
        @(negedge clk);
        a_addrs[3] = 32'h1C0; a_load_bits = 4'b1000;
        push(0, 3, 0, 32'hCAFEF00D);
        serve_a(3, 1, 32'hCAFEF00D, 32'h1C0, 32'h0, 0, hi);
        check("late_ready_strobe_cycles", 64'(hi), 64'd4);
        a_load_bits = '0;

        // Stray readyIn in IDLE and in RESPOND.
        @(negedge clk);
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        check("stray_idle_busy", 64'(a_busy), 64'd0);
        a_addrs[1] = 32'h140; a_wdata[1] = 32'h77; a_store_bits = 4'b0010;
        push(0, 1, 0, 32'hDEADBEEF);
        serve_a(0, 1, 32'h0, 32'h140, 32'h77, 1, hi);
        a_store_bits = '0;
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        check("stray_respond_busy", 64'(a_busy), 64'd0);
        @(negedge clk);
        check("stray_respond_idle", 64'(a_busy | a_store_out), 64'd0);
        check("stray_held_value", 64'(a_values[1]), 64'hDEADBEEF);

        // Asynchronous reset in the middle of ISSUE.
        a_addrs[2] = 32'h300; a_load_bits = 4'b0100;
        @(negedge clk);
        check("pre_reset_strobe", 64'(a_load_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_load", 64'(a_load_out), 64'd0);
        check("async_rst_addr", 64'(a_addr_out), 64'd0);
        check("async_rst_busy", 64'(a_busy), 64'd0);
        check("async_rst_values", 64'(|a_values), 64'd0);
        a_load_bits = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        a_ready = 1'b1; a_rdata = 32'h11111111;
        @(negedge clk);
        a_ready = 1'b0;
        check("late_ready_ignored", 64'(a_busy), 64'd0);

        // Round-robin: all ways hold requests, readyIn tied high; order 0,1,2,3,0.
        @(negedge clk);
        a_addrs = {32'h3000, 32'h2000, 32'h1000, 32'h0};
        a_load_bits = 4'b0101; a_store_bits = 4'b1010; a_ready = 1'b1; a_rdata = 32'h600D0001;
        push(0, 0, 0, 32'h600D0001);
        push(0, 1, 0, 32'h0);
        push(0, 2, 0, 32'h600D0001);
        push(0, 3, 0, 32'h0);
        push(0, 0, 0, 32'h600D0001);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            check("rr_pulse_timing", 64'(a_ready_bits != 4'b0), 64'((i % 3) == 2));
        end
        a_load_bits = '0; a_store_bits = '0; a_ready = 1'b0;

        // Fixed priority: way 0 keeps requesting and wins every time; way 1 waits.
        @(negedge clk);
        b_addrs = {32'h0, 32'h0, 32'h10, 32'h20};
        b_load_bits = 4'b0011; b_ready = 1'b1; b_rdata = 32'h0B0B0001;
        push(1, 0, 0, 32'h0B0B0001);
        push(1, 0, 0, 32'h0B0B0001);
        push(1, 0, 0, 32'h0B0B0001);
        push(1, 1, 0, 32'h0B0B0001);
        repeat (8) @(negedge clk);
        check("fixed_pulse_way0", 64'(b_ready_bits), 64'd1);
        b_load_bits = 4'b0010;
        repeat (3) @(negedge clk);
        check("fixed_pulse_way1", 64'(b_ready_bits), 64'd2);
        b_load_bits = '0; b_ready = 1'b0;

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised N-way arbiter that multiplexes load/store requests from several pipeline ports onto one downstream memory port. It supersedes the fixed two-way mediator between the pipeline stages (fetch, load/store unit, …) and the memory/bus interface. It adds configurable widths, fixed-priority or round-robin arbitration, per-way response holding, and a downstream timeout with fault reporting.

## Interface

Parameters:
- WAYS, 2, number of upstream requesters (≥1)
- ADDRESS_WIDTH, 32, address bits
- DATA_WIDTH, 32, data bits
- ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- TIMEOUT, 0, maximum ISSUE cycles before abort; 0 disables timeout

Ports:
- clockIn  input  1  single clock, all state on rising edge
- resetIn  input  1  asynchronous, active-high reset
- addressOut  output  ADDRESS_WIDTH  downstream address
- valueOut  output  DATA_WIDTH  downstream store data
- loadOut  output  1  downstream load strobe
- storeOut  output  1  downstream store strobe
- valueIn  input  DATA_WIDTH  downstream load data, valid when readyIn=1
- readyIn  input  1  downstream completion
- addressesIn  input  ADDRESS_WIDTH × [WAYS]  per-way address
- valuesOutIn  input  DATA_WIDTH × [WAYS]  per-way store data
- loadBitsIn  input  1 × [WAYS]  per-way load request
- storeBitsIn  input  1 × [WAYS]  per-way store request
- valuesInOut  output  DATA_WIDTH × [WAYS]  per-way last load result (held)
- readyBitsOut  output  1 × [WAYS]  per-way one-cycle completion pulse
- faultBitsOut  output  1 × [WAYS]  per-way one-cycle timeout pulse, coincident with readyBitsOut
- busyOut  output  1  high whenever state ≠ IDLE

## Operation

- States: IDLE, ISSUE, RESPOND.
- IDLE: a way is requesting if loadBitsIn[i] | storeBitsIn[i].
  - If none request, remain in IDLE.
  - Otherwise pick grant g. In round-robin mode, search cyclically from lastGrant+1. In fixed-priority mode, take the lowest index.
  - Register addressesIn[g] and valuesOutIn[g] into addressOut/valueOut.
  - Register the strobe: storeOut=storeBitsIn[g], loadOut=loadBitsIn[g] & ~storeBitsIn[g]. Store wins if both are set.
  - Update lastGrant=g and go to ISSUE.
- ISSUE: hold addressOut/valueOut/strobe stable.
  - On readyIn=1: capture valueIn if the operation is a load, drop the strobe, and go to RESPOND with fault=0.
  - TIMEOUT>0: the counter clears on ISSUE entry and increments on each ISSUE cycle with readyIn=0. If readyIn=0 while counter == TIMEOUT-1, drop the strobe and go to RESPOND with fault=1.
  - readyIn in the final allowed cycle completes normally; it does not fault.
- RESPOND, one cycle:
  - readyBitsOut[g]=1. faultBitsOut[g]=fault.
  - valuesInOut[g] updates only on a successful load. Stores and faults leave it unchanged.
  - Then go to IDLE.
- Upstream rule: a way holds its request and operands stable until it sees its readyBitsOut pulse, then deasserts at the following edge. A request still present in the IDLE cycle after RESPOND is treated as a new request.
- Downstream outputs are zero in IDLE and RESPOND. valueOut is zero for loads.
- readyIn outside ISSUE is ignored.
- Request changes during ISSUE/RESPOND are ignored. Operands are captured only at grant.
- Reset values:
  - state=IDLE, lastGrant=WAYS-1 (way 0 wins first), counter=0.
  - addressOut=0, valueOut=0, loadOut=0, storeOut=0.
  - all valuesInOut=0, readyBitsOut=0, faultBitsOut=0, busyOut=0.
- Reset mid-transaction abandons it asynchronously: no ready or fault pulse, and valuesInOut keeps its reset value of 0.

## Timing

- Request visible in IDLE at cycle t → strobe high at t+1 → readyIn at t+1+k → readyBitsOut pulse at t+2+k.
- Minimum request-to-ready latency is 2 cycles.
- Throughput: at most one transaction per 3 cycles (IDLE, ISSUE, RESPOND).
- Timeout: strobe is high for exactly TIMEOUT cycles, and the fault pulse follows on the next cycle.
- All outputs are registered. There is no combinational path from upstream inputs to the downstream port.

## Test plan

- Single load: way 1 loads addr 0x100, readyIn asserted 3 cycles later with valueIn 0xDEADBEEF → loadOut high for 4 cycles, readyBitsOut[1] pulses once, valuesInOut[1]=0xDEADBEEF, valuesInOut[0] stays 0.
- Round-robin fairness: WAYS=4, all ways hold requests with readyIn tied high → grant order 0,1,2,3,0, one ready pulse every 3 cycles. With ROUND_ROBIN=0 and way 0 re-requesting immediately, way 0 is served every time.
- Store and conflict: way 0 asserts load and store together, data 0x12345678 → storeOut=1, loadOut=0, valueOut=0x12345678, readyBitsOut[0] pulses, valuesInOut[0] unchanged.
- Timeout: TIMEOUT=4, readyIn held low → strobe high for 4 cycles, then readyBitsOut[g] and faultBitsOut[g] pulse together, valuesInOut[g] unchanged. Repeat with readyIn on the 4th cycle → completes with no fault.
- Reset mid-ISSUE: assert resetIn asynchronously during a load → all outputs 0 immediately and no ready pulse. A late readyIn in IDLE is ignored, and the next grant goes to way 0.
- Stray readyIn: readyIn pulsed in IDLE and in RESPOND → no state change and no extra ready pulse.
